// File: rtl/wb_pkg.sv
// wb_pkg: opcode/funct3 constants and FSM state type for the write-back stage
package wb_pkg;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: extracts and sign/zero-extends load data from a word-aligned read, flags misalignment
// Ports: funct3/off select the access, rdata is the aligned word, val is the extended result, mis flags misalignment.
module load_align
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    funct3,
  input  logic [1:0]    off,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] val,
  output logic          mis
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b, is_h;
  assign b    = rdata[{off, 3'b000} +: 8];
  assign h    = off[1] ? rdata[31:16] : rdata[15:0];
  assign is_b = funct3 == F3_LB || funct3 == F3_LBU;
  assign is_h = funct3 == F3_LH || funct3 == F3_LHU;
  // funct3[2] marks the unsigned variants; anything not byte/half behaves as a word load
  assign val  = is_b ? {{(DW-8){b[7] & ~funct3[2]}}, b}
              : is_h ? {{(DW-16){h[15] & ~funct3[2]}}, h}
              : rdata;
  assign mis  = is_h ? off[0] : !is_b && |off;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered write-back stage; decodes RF writes, holds loads until mem_rvalid, aligns load data
// Ports: in_valid/in_ready/in_inst/in_data/rf_we_e accept a retiring instruction; mem_rvalid/mem_rdata return
// load data; rf_we/wreg/wdata drive the register file; retire/misalign pulse once per completed instruction.
// WB_BYPASS_EN adds byp_valid/byp_reg/byp_data (next-cycle write preview) and load_pend/load_rd (pending load).
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW  = 32,
  parameter int IW  = 32,
  parameter int RFW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_inst,
  input  logic [DW-1:0]  in_data,
  input  logic           rf_we_e,
  input  logic           mem_rvalid,
  input  logic [DW-1:0]  mem_rdata,
  output logic           rf_we,
  output logic [RFW-1:0] wreg,
  output logic [DW-1:0]  wdata,
  output logic           retire,
  output logic           misalign
`ifdef WB_BYPASS_EN
  ,
  output logic           byp_valid,
  output logic [RFW-1:0] byp_reg,
  output logic [DW-1:0]  byp_data,
  output logic           load_pend,
  output logic [RFW-1:0] load_rd
`endif
);
  state_t         state, state_n;
  logic [6:0]     op;
  logic [RFW-1:0] in_rd, l_rd, n_reg;
  logic [2:0]     l_f3;
  logic [1:0]     l_off;
  logic           l_we, acc, is_load, wr_op, done, mis, n_we, n_ret, n_mis;
  logic [DW-1:0]  val, n_data;
  assign op       = in_inst[6:0];
  assign in_rd    = in_inst[7+RFW-1:7];
  assign in_ready = state == IDLE && !rst;
  assign acc      = in_valid && in_ready;
  assign is_load  = op == OP_LOAD;
  assign wr_op    = op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  assign done     = state == WAIT_MEM && mem_rvalid && !rst;
  load_align #(.DW(DW)) u_align (
    .funct3(l_f3),
    .off   (l_off),
    .rdata (mem_rdata),
    .val   (val),
    .mis   (mis)
  );
  always_comb begin
    state_n = state;
    n_ret   = 1'b0;
    n_we    = 1'b0;
    n_mis   = 1'b0;
    n_reg   = wreg;
    n_data  = wdata;
    if (acc) begin
      state_n = is_load ? WAIT_MEM : IDLE;
      n_ret   = !is_load;
      n_reg   = is_load ? wreg : in_rd;
      n_data  = is_load ? wdata : in_data;
      n_we    = !is_load && wr_op && |in_rd && rf_we_e;
    end
    if (done) begin
      state_n = IDLE;
      n_ret   = 1'b1;
      n_mis   = mis;
      n_reg   = l_rd;
      n_data  = mis ? '0 : val;
      n_we    = !mis && |l_rd && l_we;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      retire   <= 1'b0;
      misalign <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
    end else begin
      rf_we    <= n_we;
      retire   <= n_ret;
      misalign <= n_mis;
      wreg     <= n_reg;
      wdata    <= n_data;
    end
  end
  always_ff @(posedge clk) begin
    if (acc && is_load) begin
      l_rd  <= in_rd;
      l_f3  <= in_inst[14:12];
      l_off <= in_data[1:0];
      l_we  <= rf_we_e;
    end
  end
`ifdef WB_BYPASS_EN
  assign byp_valid = n_we;
  assign byp_reg   = n_reg;
  assign byp_data  = n_data;
  assign load_pend = state == WAIT_MEM && |l_rd;
  assign load_rd   = l_rd;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, rf_we_e, mem_rvalid, rf_we, retire, misalign;
  logic [31:0] in_inst, in_data, mem_rdata, wdata;
  logic [4:0]  wreg;
  int          n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_data   (in_data),
    .rf_we_e   (rf_we_e),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .rf_we     (rf_we),
    .wreg      (wreg),
    .wdata     (wdata),
    .retire    (retire),
    .misalign  (misalign)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] inst, input logic [31:0] data, input logic we);
    in_valid = 1'b1;
    in_inst  = inst;
    in_data  = data;
    rf_we_e  = we;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic respond(input logic [31:0] rdata);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_data = '0; rf_we_e = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_wreg", wreg, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);
    @(negedge clk);
    issue(32'h00A302B3, 32'h1234, 1'b1);
    chk("add_rf_we", rf_we, 1);
    chk("add_wreg", wreg, 5);
    chk("add_wdata", wdata, 32'h1234);
    chk("add_retire", retire, 1);
    @(negedge clk);
    chk("idle_retire", retire, 0);
    chk("idle_rf_we", rf_we, 0);
    chk("hold_wdata", wdata, 32'h1234);
    issue(32'h00A302B3, 32'h55, 1'b0);
    chk("add_we_e0_rf_we", rf_we, 0);
    chk("add_we_e0_retire", retire, 1);
    issue(32'h00100013, 32'hFFFF, 1'b1);
    chk("addi_x0_retire", retire, 1);
    chk("addi_x0_rf_we", rf_we, 0);
    chk("addi_x0_wdata", wdata, 32'hFFFF);
    respond(32'hDEADBEEF);
    chk("rvalid_idle_retire", retire, 0);
    issue(32'h00000383, 32'h1003, 1'b1);
    chk("lb_wait_retire", retire, 0);
    chk("lb_wait_ready0", in_ready, 0);
    @(negedge clk);
    chk("lb_wait_ready1", in_ready, 0);
    @(negedge clk);
    chk("lb_wait_ready2", in_ready, 0);
    respond(32'h80FFFFFF);
    chk("lb_wdata", wdata, 32'hFFFFFF80);
    chk("lb_wreg", wreg, 7);
    chk("lb_rf_we", rf_we, 1);
    chk("lb_retire", retire, 1);
    chk("lb_ready", in_ready, 1);
    issue(32'h00005403, 32'h2002, 1'b1);
    respond(32'hBEEF0000);
    chk("lhu_wdata", wdata, 32'h0000BEEF);
    chk("lhu_wreg", wreg, 8);
    chk("lhu_rf_we", rf_we, 1);
    issue(32'h00001503, 32'h2002, 1'b1);
    respond(32'h80010000);
    chk("lh_wdata", wdata, 32'hFFFF8001);
    issue(32'h00004383, 32'h1001, 1'b1);
    respond(32'h0000A500);
    chk("lbu_wdata", wdata, 32'h000000A5);
    issue(32'h00002483, 32'h101, 1'b1);
    respond(32'h12345678);
    chk("lw_mis_misalign", misalign, 1);
    chk("lw_mis_rf_we", rf_we, 0);
    chk("lw_mis_retire", retire, 1);
    chk("lw_mis_wdata", wdata, 0);
    @(negedge clk);
    chk("mis_pulse_end", misalign, 0);
    issue(32'h00002483, 32'h100, 1'b1);
    respond(32'hCAFEF00D);
    chk("lw_wdata", wdata, 32'hCAFEF00D);
    chk("lw_misalign", misalign, 0);
    in_valid = 1'b1; in_inst = 32'h00A302B3; in_data = 32'h11; rf_we_e = 1'b1;
    @(negedge clk);
    chk("b2b_add_retire", retire, 1);
    chk("b2b_add_rf_we", rf_we, 1);
    chk("b2b_add_wdata", wdata, 32'h11);
    in_inst = 32'h00532023; in_data = 32'h22;
    @(negedge clk);
    chk("b2b_sw_retire", retire, 1);
    chk("b2b_sw_rf_we", rf_we, 0);
    in_inst = 32'h000000EF; in_data = 32'h33;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_jal_retire", retire, 1);
    chk("b2b_jal_rf_we", rf_we, 1);
    chk("b2b_jal_wreg", wreg, 1);
    chk("b2b_jal_wdata", wdata, 32'h33);
    issue(32'h00002583, 32'h200, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    #1 chk("rst_wait_ready", in_ready, 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_wait_retire", retire, 0);
    chk("rst_wait_rf_we", rf_we, 0);
    @(negedge clk);
    chk("rst_wait_retire2", retire, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered write-back stage for the RISC pipeline. It accepts one retiring instruction per cycle with a valid/ready handshake and decodes which instructions write the register file: R, I, LUI, AUIPC, JAL, JALR and loads. Loads are held until the data memory returns read data, then aligned and sign/zero-extended before being driven to the register-file write port. It sits between the execute/memory stage and the register file and replaces the purely combinational write-back decode.

## Interface
- DW, 32, data/register width (≥32)
- IW, 32, instruction width
- RFW, 5, register-address width (rd = in_inst[7+RFW-1:7])

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction + result offered
- in_ready  out  1  stage can accept (combinational, = state==IDLE && !rst)
- in_inst  in  IW  retiring instruction
- in_data  in  DW  ALU result; for loads, the effective address
- rf_we_e  in  1  write-enable qualifier, sampled at acceptance
- mem_rvalid  in  1  load data valid (single-cycle pulse)
- mem_rdata  in  DW  load read data, word-aligned
- rf_we  out  1  register-file write strobe (registered)
- wreg  out  RFW  destination register (registered)
- wdata  out  DW  write data (registered)
- retire  out  1  one-cycle pulse per completed instruction
- misalign  out  1  one-cycle pulse for a misaligned load; no write

## Operation
- FSM states: IDLE, WAIT_MEM.
- IDLE, handshake (in_valid && in_ready):
  - opcode 0x03: latch rd, funct3, in_data[1:0], rf_we_e; go to WAIT_MEM.
  - Else: next cycle retire=1, wreg=rd, wdata=in_data; rf_we=1 only if opcode ∈ {0x33, 0x13, 0x37, 0x17, 0x6F, 0x67}, rd≠0 and rf_we_e=1. Stay in IDLE.
- Stores (0x23), branches (0x63) and unknown opcodes retire with rf_we=0.
- WAIT_MEM: in_ready=0. On mem_rvalid, the next cycle:
  - retire=1, wdata = extracted value;
  - rf_we=1 if rd≠0 and latched rf_we_e=1;
  - return to IDLE.
- Load extraction by funct3 and byte offset `off`:
  - LB 000 / LBU 100: byte `off`, sign- / zero-extended.
  - LH 001 / LHU 101: halfword off[1]; sign- / zero-extended.
  - LW 010: full word.
  - Other funct3 values: treated as LW.
- Misaligned load (LH/LHU with off[0]=1, LW with off≠0): retire=1, misalign=1, rf_we=0, wdata=0.
- mem_rvalid in IDLE is ignored. mem_rvalid in the cycle a load is accepted is ignored; memory responds ≥1 cycle later.
- Outputs not being updated hold rf_we=0, retire=0, misalign=0. wreg and wdata hold their last value.

## Timing
- Reset: state=IDLE, rf_we=0, retire=0, misalign=0, wreg=0, wdata=0, in_ready=0 while rst high.
- Non-load latency: 1 cycle from handshake to rf_we/retire. Throughput: 1 per cycle.
- Load latency: mem_rvalid cycle + 1. in_ready returns high in the same cycle the load's write is presented.
- Reset during WAIT_MEM abandons the load: no write, no retire.

## Configuration
- WB_BYPASS_EN defined: adds the following outputs:
  - byp_valid (1), byp_reg (RFW), byp_data (DW): combinational copy of the value that will be registered into wdata next cycle; byp_valid=1 only when that write has rf_we=1.
  - load_pend (1), load_rd (RFW): high in WAIT_MEM with the latched rd when rd≠0, so the hazard unit stalls dependants.
- Undefined: these ports do not exist and no bypass logic is built.

## Structure
- Package wb_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR;
  - load funct3 constants;
  - the state enum {IDLE, WAIT_MEM}.
- One combinational sub-module, load_align: funct3, offset, mem_rdata → extracted value and misalign flag.

## Test plan
- ADD x5 (inst 0x00A302B3), in_data=0x1234, rf_we_e=1 → next cycle rf_we=1, wreg=5, wdata=0x1234, retire=1.
- ADDI to x0, in_data=0xFFFF → retire=1, rf_we=0.
- LB x7, in_data=...0x03, mem_rvalid 3 cycles later with rdata=0x80FFFFFF → in_ready=0 during the wait; then wdata=0xFFFFFF80, wreg=7, rf_we=1.
- LHU offset 2, rdata=0xBEEF0000 → wdata=0x0000BEEF. LW offset 1 → misalign=1, rf_we=0.
- Back-to-back ADD, SW, JAL x1 on consecutive cycles → retire on 3 consecutive cycles; rf_we = 1, 0, 1.
- rst asserted during WAIT_MEM, then mem_rvalid → no rf_we, no retire, in_ready=1 after rst falls.
